// File: rtl/msrv32_dmem_ctrl_if.sv
// Pipeline-side load/store request, AHB-lite style data bus, and completion
// response of the data memory controller, bundled in one interface.
//
// Request handshake: a request transfers on a rising edge where req_valid_in
// and req_ready_out are both high. The requester holds its fields stable
// while req_valid_in is high and req_ready_out is low. The response is a
// single-cycle rsp_valid_out pulse with no back-pressure; rsp_data_out,
// rsp_err_out and misaligned_out stay valid until the next pulse.
interface msrv32_dmem_ctrl_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_write_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [3:0]  wr_mask_out;
  logic [31:0] hwdata_out;
  logic        hready_in;
  logic        hresp_in;
  logic [31:0] hrdata_in;
  logic        rsp_valid_out;
  logic [31:0] rsp_data_out;
  logic        rsp_err_out;
  logic        misaligned_out;
  logic        stall_out;

  // Controller side (it is the bus master).
  modport master (
    input  req_valid_in, req_write_in, load_size_in, load_unsigned_in,
           addr_in, wdata_in, hready_in, hresp_in, hrdata_in,
    output req_ready_out, haddr_out, htrans_out, hwrite_out, hsize_out,
           wr_mask_out, hwdata_out, rsp_valid_out, rsp_data_out,
           rsp_err_out, misaligned_out, stall_out
  );

  // Pipeline plus bus-slave side.
  modport slave (
    output req_valid_in, req_write_in, load_size_in, load_unsigned_in,
           addr_in, wdata_in, hready_in, hresp_in, hrdata_in,
    input  req_ready_out, haddr_out, htrans_out, hwrite_out, hsize_out,
           wr_mask_out, hwdata_out, rsp_valid_out, rsp_data_out,
           rsp_err_out, misaligned_out, stall_out
  );
endinterface

// File: rtl/msrv32_dmem_ctrl.sv
// Data memory controller: accepts one load/store at a time from the pipeline,
// runs a single AHB-lite style transfer (address phase, then data phase),
// aligns store data to byte lanes, extracts and extends load data, and
// reports completion, bus error / timeout, or misalignment.
module msrv32_dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  msrv32_dmem_ctrl_if.master  bus,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_ERR2 = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        write_q, unsigned_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [7:0]  cnt_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q, rsp_mis_q;

  logic        accept, req_misaligned;
  logic        resp_load, resp_err, resp_mis, resp_capture;
  logic        bus_active;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [3:0]  store_mask;
  logic [31:0] store_data;
  logic [2:0]  hsize_d;

  assign accept = (state_q == S_IDLE) && bus.req_valid_in;

  // Half needs an even address, word needs a word-aligned address.
  assign req_misaligned = (bus.load_size_in == 2'b01) ? bus.addr_in[0]
                        : (bus.load_size_in[1])       ? (bus.addr_in[1:0] != 2'b00)
                        : 1'b0;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next state, plus what gets recorded on the way into RESP.
  always_comb begin
    state_d      = state_q;
    resp_load    = 1'b0;
    resp_err     = 1'b0;
    resp_mis     = 1'b0;
    resp_capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_in) begin
          if (req_misaligned) begin
            state_d   = S_RESP;
            resp_load = 1'b1;
            resp_mis  = 1'b1;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (bus.hready_in) state_d = S_DATA;
      end
      S_DATA: begin
        if (bus.hresp_in) begin
          // Two-cycle error response: wait for its second cycle in ERR2.
          if (bus.hready_in) begin
            state_d   = S_RESP;
            resp_load = 1'b1;
            resp_err  = 1'b1;
          end else begin
            state_d = S_ERR2;
          end
        end else if (bus.hready_in) begin
          state_d      = S_RESP;
          resp_load    = 1'b1;
          resp_capture = !write_q;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_RESP;
          resp_load = 1'b1;
          resp_err  = 1'b1;
        end
      end
      S_ERR2: begin
        if (bus.hready_in) begin
          state_d   = S_RESP;
          resp_load = 1'b1;
          resp_err  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are captured once at acceptance and held for the transfer.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else if (accept) begin
      write_q    <= bus.req_write_in;
      unsigned_q <= bus.load_unsigned_in;
      size_q     <= bus.load_size_in;
      addr_q     <= bus.addr_in;
      wdata_q    <= bus.wdata_in;
    end
  end

  // Data-phase wait counter: zero outside DATA, counts not-ready cycles inside.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                cnt_q <= 8'h0;
    else if (state_q != S_DATA)   cnt_q <= 8'h0;
    else if (!bus.hready_in)      cnt_q <= cnt_q + 8'd1;
  end

  // Response fields update only when entering RESP, then hold.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
      rsp_mis_q  <= 1'b0;
    end else if (resp_load) begin
      rsp_data_q <= resp_capture ? load_data : 32'h0;
      rsp_err_q  <= resp_err;
      rsp_mis_q  <= resp_mis;
    end
  end

  assign lane_byte = bus.hrdata_in[{addr_q[1:0], 3'b000} +: 8];
  assign lane_half = bus.hrdata_in[{addr_q[1], 4'b0000} +: 16];

  // Load lane select and sign/zero extension.
  always_comb begin
    load_data = bus.hrdata_in;
    case (size_q)
      2'b00:   load_data = unsigned_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_data = unsigned_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_data = bus.hrdata_in;
    endcase
  end

  // Store lane enables and replicated write data.
  always_comb begin
    store_mask = 4'b1111;
    store_data = wdata_q;
    case (size_q)
      2'b00: begin
        store_mask = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        store_mask = 4'b0011 << addr_q[1:0];
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        store_mask = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  assign hsize_d    = (size_q == 2'b00) ? 3'b000 : (size_q == 2'b01) ? 3'b001 : 3'b010;
  assign bus_active = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_ERR2);

  // Bus controls are zero whenever no transfer is in flight.
  assign bus.htrans_out     = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign bus.haddr_out      = bus_active ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.hwrite_out     = bus_active && write_q;
  assign bus.hsize_out      = bus_active ? hsize_d : 3'b000;
  assign bus.wr_mask_out    = (write_q && ((state_q == S_ADDR) || (state_q == S_DATA))) ? store_mask : 4'b0000;
  assign bus.hwdata_out     = (write_q && (state_q == S_DATA)) ? store_data : 32'h0;
  assign bus.req_ready_out  = (state_q == S_IDLE);
  assign bus.stall_out      = (state_q != S_IDLE);
  assign bus.rsp_valid_out  = (state_q == S_RESP);
  assign bus.rsp_data_out   = rsp_data_q;
  assign bus.rsp_err_out    = rsp_err_q;
  assign bus.misaligned_out = rsp_mis_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// Directed bench for msrv32_dmem_ctrl: a driver issues requests and plays the
// bus slave; expected responses and bus address phases go into queues that
// two monitors pop and compare when the DUT presents them.
module tb_msrv32_dmem_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         cyc;
  int         checks;
  int         errors;

  // Response record: {latency[7:0], err, misaligned, data[31:0]}
  logic [41:0] exp_q[$];
  // Bus record: {haddr[31:0], hwrite, hsize[2:0], wr_mask[3:0], hwdata[31:0]}
  logic [71:0] exp_bus_q[$];
  int          acc_q[$];

  msrv32_dmem_ctrl_if bus();

  msrv32_dmem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [41:0] mk_rsp(input int lat, input logic err, input logic mis,
                                         input logic [31:0] data);
    return {8'(lat), err, mis, data};
  endfunction

  function automatic logic [71:0] mk_bus(input logic [31:0] haddr, input logic hwrite,
                                         input logic [2:0] hsize, input logic [3:0] mask,
                                         input logic [31:0] hwdata);
    return {haddr, hwrite, hsize, mask, hwdata};
  endfunction

  // ---------------- scoreboard monitors ----------------
  // Sample 1 time unit after the falling edge: values seen here are the ones
  // the next rising edge will act on.
  initial begin : rsp_monitor
    logic [41:0] e;
    int          a;
    forever begin
      @(negedge clk); #1;
      if (rst_n && bus.rsp_valid_out) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid with nothing expected (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rsp", {38'h0, 8'(cyc + 1 - a), bus.rsp_err_out, bus.misaligned_out, bus.rsp_data_out},
              {38'h0, e});
        end
      end
    end
  end

  initial begin : bus_monitor
    logic [71:0] eb;
    logic        data_next;
    logic [31:0] exp_hwdata;
    data_next  = 1'b0;
    exp_hwdata = 32'h0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        data_next = 1'b0;
      end else begin
        if (data_next) begin
          data_next = 1'b0;
          chk("hwdata", {48'h0, bus.hwdata_out}, {48'h0, exp_hwdata});
        end
        if (bus.htrans_out == 2'b10 && bus.hready_in) begin
          if (exp_bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL nonseq_unexpected: got NONSEQ haddr %h with none expected (t=%0t)",
                     bus.haddr_out, $time);
          end else begin
            eb = exp_bus_q.pop_front();
            chk("addr_phase", {40'h0, bus.haddr_out, bus.hwrite_out, bus.hsize_out, bus.wr_mask_out},
                {40'h0, eb[71:32]});
            exp_hwdata = eb[31:0];
            data_next  = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // mode: 0 normal, 1 two-cycle error response, 2 timeout, 3 misaligned (no bus)
  task automatic do_txn(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int aw, input int dw, input int mode,
                        input logic [41:0] exp_rsp, input logic [71:0] exp_bus);
    int n;
    exp_q.push_back(exp_rsp);
    if (mode != 3) exp_bus_q.push_back(exp_bus);
    bus.req_write_in     = wr;
    bus.load_size_in     = sz;
    bus.load_unsigned_in = uns;
    bus.addr_in          = addr;
    bus.wdata_in         = wdata;
    bus.hrdata_in        = rdata;
    bus.hready_in        = 1'b1;
    bus.hresp_in         = 1'b0;
    bus.req_valid_in     = 1'b1;
    n = 0;
    while (!bus.req_ready_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n == 20) begin
      errors++;
      $display("FAIL accept_timeout: req_ready never high (t=%0t)", $time);
    end
    @(negedge clk);
    acc_q.push_back(cyc);
    // Request inputs change after acceptance; the transfer must not notice.
    bus.req_valid_in     = 1'b0;
    bus.addr_in          = $urandom;
    bus.wdata_in         = $urandom;
    bus.req_write_in     = 1'($urandom_range(0, 1));
    bus.load_size_in     = 2'($urandom_range(0, 3));
    bus.load_unsigned_in = 1'($urandom_range(0, 1));
    if (mode != 3) begin
      if (aw > 0) begin
        bus.hready_in = 1'b0;
        repeat (aw) @(negedge clk);
        bus.hready_in = 1'b1;
      end
      @(negedge clk);
      if (mode == 0) begin
        if (dw > 0) begin
          bus.hready_in = 1'b0;
          repeat (dw) @(negedge clk);
          bus.hready_in = 1'b1;
        end
        @(negedge clk);
      end else if (mode == 1) begin
        bus.hready_in = 1'b0;
        bus.hresp_in  = 1'b1;
        @(negedge clk);
        bus.hready_in = 1'b1;
        @(negedge clk);
        bus.hresp_in  = 1'b0;
      end else begin
        bus.hready_in = 1'b0;
        repeat (16) @(negedge clk);
        // Slave finally answers while the controller is already responding.
        bus.hready_in = 1'b1;
        @(negedge clk);
        bus.hready_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.hready_in = 1'b1;
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout: no response for addr %h (t=%0t)", addr, $time);
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
    chk("rsp_hold", {48'h0, bus.rsp_data_out}, {48'h0, exp_rsp[31:0]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n                = 1'b0;
    bus.req_valid_in     = 1'b0;
    bus.req_write_in     = 1'b0;
    bus.load_size_in     = 2'b00;
    bus.load_unsigned_in = 1'b0;
    bus.addr_in          = 32'h0;
    bus.wdata_in         = 32'h0;
    bus.hready_in        = 1'b1;
    bus.hresp_in         = 1'b0;
    bus.hrdata_in        = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_bus", {6'h0, bus.htrans_out, bus.haddr_out, bus.hwrite_out, bus.hsize_out,
                      bus.wr_mask_out, bus.hwdata_out}, 80'h0);
    chk("reset_rsp", {44'h0, bus.rsp_valid_out, bus.rsp_data_out, bus.rsp_err_out,
                      bus.misaligned_out, bus.stall_out}, 80'h0);
    chk("reset_ready", {79'h0, bus.req_ready_out}, 80'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed byte load, lane 3.
    do_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 0, 0, 0,
           mk_rsp(3, 1'b0, 1'b0, 32'hFFFF_FF80), mk_bus(32'h0000_1000, 1'b0, 3'b000, 4'b0000, 32'h0));
    // Half store, upper half, one address wait and one data wait.
    do_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1, 1, 0,
           mk_rsp(5, 1'b0, 1'b0, 32'h0), mk_bus(32'h0000_2000, 1'b1, 3'b001, 4'b1100, 32'hBEEF_BEEF));
    // Misaligned word load: straight to response, no bus transfer.
    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 3,
           mk_rsp(1, 1'b0, 1'b1, 32'h0), 72'h0);
    // Unsigned half load with a two-cycle error response.
    do_txn(1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'h0, 32'h1234_5678, 0, 0, 1,
           mk_rsp(4, 1'b1, 1'b0, 32'h0), mk_bus(32'h0000_4000, 1'b0, 3'b001, 4'b0000, 32'h0));
    // Word load timing out after 16 data cycles; late hready ignored.
    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 32'h5555_AAAA, 0, 0, 2,
           mk_rsp(18, 1'b1, 1'b0, 32'h0), mk_bus(32'h0000_5000, 1'b0, 3'b010, 4'b0000, 32'h0));
    // Unsigned byte load lane 1, two data waits.
    do_txn(1'b0, 2'b00, 1'b1, 32'h0000_6001, 32'h0, 32'hA1B2_C3D4, 0, 2, 0,
           mk_rsp(5, 1'b0, 1'b0, 32'h0000_00C3), mk_bus(32'h0000_6000, 1'b0, 3'b000, 4'b0000, 32'h0));
    // Signed half load, upper lane.
    do_txn(1'b0, 2'b01, 1'b0, 32'h0000_7002, 32'h0, 32'h8001_1234, 0, 0, 0,
           mk_rsp(3, 1'b0, 1'b0, 32'hFFFF_8001), mk_bus(32'h0000_7000, 1'b0, 3'b001, 4'b0000, 32'h0));
    // Byte store to lane 1.
    do_txn(1'b1, 2'b00, 1'b0, 32'h0000_8001, 32'h1234_56A5, 32'h0, 0, 0, 0,
           mk_rsp(3, 1'b0, 1'b0, 32'h0), mk_bus(32'h0000_8000, 1'b1, 3'b000, 4'b0010, 32'hA5A5_A5A5));
    // Word store.
    do_txn(1'b1, 2'b10, 1'b0, 32'h0000_9000, 32'hDEAD_BEEF, 32'h0, 0, 0, 0,
           mk_rsp(3, 1'b0, 1'b0, 32'h0), mk_bus(32'h0000_9000, 1'b1, 3'b010, 4'b1111, 32'hDEAD_BEEF));
    // Misaligned half store.
    do_txn(1'b1, 2'b01, 1'b0, 32'h0000_A001, 32'h0000_1111, 32'h0, 0, 0, 3,
           mk_rsp(1, 1'b0, 1'b1, 32'h0), 72'h0);
    // Word load (size 11) with three address-phase waits.
    do_txn(1'b0, 2'b11, 1'b0, 32'h0000_B004, 32'h0, 32'hCAFE_F00D, 3, 0, 0,
           mk_rsp(6, 1'b0, 1'b0, 32'hCAFE_F00D), mk_bus(32'h0000_B004, 1'b0, 3'b010, 4'b0000, 32'h0));

    // Reset during the data phase: everything drops at once, no response.
    exp_bus_q.push_back(mk_bus(32'h0000_D000, 1'b0, 3'b010, 4'b0000, 32'h0));
    bus.req_write_in     = 1'b0;
    bus.load_size_in     = 2'b10;
    bus.load_unsigned_in = 1'b0;
    bus.addr_in          = 32'h0000_D000;
    bus.hrdata_in        = 32'h7777_7777;
    bus.hready_in        = 1'b1;
    bus.req_valid_in     = 1'b1;
    @(negedge clk);
    bus.req_valid_in = 1'b0;
    @(negedge clk);
    bus.hready_in = 1'b0;
    @(negedge clk);
    chk("pre_reset_stall", {79'h0, bus.stall_out}, 80'h1);
    rst_n = 1'b0;
    #1;
    chk("midreset_bus", {6'h0, bus.htrans_out, bus.haddr_out, bus.hwrite_out, bus.hsize_out,
                         bus.wr_mask_out, bus.hwdata_out}, 80'h0);
    chk("midreset_rsp", {44'h0, bus.rsp_valid_out, bus.rsp_data_out, bus.rsp_err_out,
                         bus.misaligned_out, bus.stall_out}, 80'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.hready_in = 1'b1;

    // Normal request right after reset release.
    do_txn(1'b0, 2'b00, 1'b0, 32'h0000_C000, 32'h0, 32'h0000_00FE, 0, 0, 0,
           mk_rsp(3, 1'b0, 1'b0, 32'hFFFF_FFFE), mk_bus(32'h0000_C000, 1'b0, 3'b000, 4'b0000, 32'h0));

    repeat (3) @(negedge clk);
    chk("queues_empty", 80'(exp_q.size() + exp_bus_q.size() + acc_q.size()), 80'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
